// File: rtl/iomem_gray_fifo.sv
// RGB888 -> 8-bit luma converter on the iomem bus: 2-stage multiply/sum pipeline
// feeding a circular FIFO drained by CPU reads, with a level interrupt on FIFO fill.
module iomem_gray_fifo #(
  parameter logic [31:0] ADDR_BASE = 32'h0300_0000,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IRQ_LEVEL = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iomem_valid,
  output logic        iomem_ready,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] IrqC   = CW'(IRQ_LEVEL);

  localparam logic [1:0] OffPixIn  = 2'd0;
  localparam logic [1:0] OffPixOut = 2'd1;
  localparam logic [1:0] OffStatus = 2'd2;
  localparam logic [1:0] OffCtrl   = 2'd3;

  // Bus and control state
  logic          ready_q;
  logic [31:0]   rdata_q;
  logic          irq_q;
  logic          enable_q;
  logic          invert_q;
  logic          ovf_q;
  logic          udf_q;
  logic          nonempty_q;

  // Pipeline state
  logic          s1_valid_q;
  logic [15:0]   p_r_q, p_g_q, p_b_q;
  logic          s2_valid_q;
  logic [7:0]    s2_y_q;

  // FIFO state
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;

  logic          sel, access, is_write;
  logic [1:0]    offset;
  logic          wr_pix, rd_pix, wr_stat, wr_ctrl, flush;
  logic          accept, drop, do_pop, push, underflow_evt;
  logic [CW-1:0] in_flight, occupancy;
  logic [15:0]   sum;
  logic [7:0]    y_next;
  logic          busy, empty, full;
  logic [31:0]   status_word;
  logic [31:0]   rdata_d;
  logic          unused_bits;

  assign sel      = iomem_valid && (iomem_addr[31:4] == ADDR_BASE[31:4]);
  assign access   = ready_q && sel;
  assign is_write = |iomem_wstrb;
  assign offset   = iomem_addr[3:2];

  assign wr_pix  = access && is_write && (offset == OffPixIn);
  assign rd_pix  = access && !is_write && (offset == OffPixOut);
  assign wr_stat = access && is_write && (offset == OffStatus);
  assign wr_ctrl = access && (offset == OffCtrl) && iomem_wstrb[0];
  assign flush   = wr_ctrl && iomem_wdata[1];

  // Counting in-flight pixels against capacity means the FIFO can never overflow.
  assign in_flight = CW'(s1_valid_q) + CW'(s2_valid_q);
  assign occupancy = count_q + in_flight;
  assign accept    = wr_pix && enable_q && (occupancy < DepthC);
  assign drop      = wr_pix && enable_q && !(occupancy < DepthC);

  // Pop decision uses the emptiness seen when rdata was captured, so data and pop agree.
  assign do_pop        = rd_pix && nonempty_q;
  assign underflow_evt = rd_pix && !nonempty_q;
  assign push          = s2_valid_q;

  assign sum    = p_r_q + p_g_q + p_b_q;
  assign y_next = invert_q ? ~sum[15:8] : sum[15:8];

  assign busy  = s1_valid_q || s2_valid_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == DepthC);
  assign status_word = {15'd0, 9'(count_q), 3'd0, busy, udf_q, ovf_q, full, empty};

  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata[31:24]};

  always_comb begin
    rdata_d = 32'd0;
    if (sel && !ready_q && !is_write) begin
      unique case (offset)
        OffPixIn:  rdata_d = 32'd0;
        OffPixOut: rdata_d = empty ? 32'd0 : {1'b1, 23'd0, mem[rptr_q]};
        OffStatus: rdata_d = status_word;
        OffCtrl:   rdata_d = {29'd0, invert_q, 1'b0, enable_q};
        default:   rdata_d = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q    <= 1'b0;
      rdata_q    <= 32'd0;
      irq_q      <= 1'b0;
      enable_q   <= 1'b1;
      invert_q   <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      nonempty_q <= 1'b0;
    end else begin
      ready_q    <= sel && !ready_q;
      rdata_q    <= rdata_d;
      irq_q      <= enable_q && (count_q >= IrqC);
      nonempty_q <= !empty;
      if (wr_ctrl) begin
        enable_q <= iomem_wdata[0];
        invert_q <= iomem_wdata[2];
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (wr_stat && iomem_wdata[2]) begin
        ovf_q <= 1'b0;
      end
      if (underflow_evt) begin
        udf_q <= 1'b1;
      end else if (wr_stat && iomem_wdata[3]) begin
        udf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      p_r_q <= 16'(iomem_wdata[23:16]) * 16'd77;
      p_g_q <= 16'(iomem_wdata[15:8]) * 16'd150;
      p_b_q <= 16'(iomem_wdata[7:0]) * 16'd29;
    end
    if (s1_valid_q) begin
      s2_y_q <= y_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= s2_y_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_gray_fifo.sv
// Bench for iomem_gray_fifo: directed vector table, hand-written corner sequences,
// then random bus traffic checked against a timestamped queue model.
module tb_iomem_gray_fifo;

  localparam logic [31:0] Base = 32'h0300_0000;
  localparam int Depth = 16;
  localparam int IrqLevel = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        irq;

  iomem_gray_fifo #(
    .ADDR_BASE(Base),
    .DEPTH    (Depth),
    .IRQ_LEVEL(IrqLevel)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [31:0] last_rd;
  int          last_cyc;
  logic        last_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction; valid held through the ready cycle, dropped just after it.
  task automatic bus(input logic wr, input logic [1:0] off, input logic [31:0] wd,
                     input logic [3:0] ws);
    int lat;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = Base + {28'd0, off, 2'b00};
    iomem_wdata = wd;
    iomem_wstrb = wr ? ws : 4'h0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!iomem_ready && lat < 8);
    chk("ready_latency", lat, 1);
    last_rd  = iomem_rdata;
    last_cyc = cyc;
    last_irq = irq;
    @(posedge clk);
    #1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  off;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic [31:0] exp;
    int          gap;
  } vec_t;

  vec_t vecs[16];

  // Reference model state
  typedef struct {
    int y;
    int land;
  } ent_t;
  ent_t pq[$];
  bit   m_en, m_inv, m_ovf, m_udf;

  function automatic int luma(input logic [31:0] p, input bit inv);
    int y;
    y = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
    return inv ? 255 - y : y;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int hits;
    reset = 1'b1;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    iomem_addr = 32'h0;
    iomem_wdata = 32'h0;
    do_reset();

    // Reset state and single-cycle ready pulse
    chk("reset_ready", iomem_ready, 0);
    chk("reset_rdata", iomem_rdata, 0);
    chk("reset_irq", irq, 0);
    bus(1'b0, 2'd2, 32'h0, 4'h0);
    chk("status_after_reset", last_rd, 32'h0000_0001);
    chk("irq_after_reset", last_irq, 0);
    @(negedge clk);
    chk("ready_one_cycle", iomem_ready, 0);
    chk("rdata_idle", iomem_rdata, 0);

    vecs[0]  = '{1'b1, 2'd0, 32'h00FF_FFFF, 4'hF, 32'h0, 3};
    vecs[1]  = '{1'b0, 2'd1, 32'h0, 4'h0, 32'h8000_00FF, 0};
    vecs[2]  = '{1'b1, 2'd0, 32'h0000_0000, 4'h1, 32'h0, 3};
    vecs[3]  = '{1'b0, 2'd1, 32'h0, 4'h0, 32'h8000_0000, 0};
    vecs[4]  = '{1'b1, 2'd0, 32'h00FF_0000, 4'h8, 32'h0, 3};
    vecs[5]  = '{1'b0, 2'd1, 32'h0, 4'h0, 32'h8000_004C, 0};
    vecs[6]  = '{1'b1, 2'd3, 32'h0000_0005, 4'h1, 32'h0, 0};
    vecs[7]  = '{1'b0, 2'd3, 32'h0, 4'h0, 32'h0000_0005, 0};
    vecs[8]  = '{1'b1, 2'd0, 32'h00FF_0000, 4'hF, 32'h0, 3};
    vecs[9]  = '{1'b0, 2'd1, 32'h0, 4'h0, 32'h8000_00B3, 0};
    vecs[10] = '{1'b1, 2'd3, 32'h0000_0000, 4'h2, 32'h0, 0};
    vecs[11] = '{1'b0, 2'd3, 32'h0, 4'h0, 32'h0000_0005, 0};
    vecs[12] = '{1'b1, 2'd3, 32'h0000_0001, 4'h1, 32'h0, 0};
    vecs[13] = '{1'b0, 2'd3, 32'h0, 4'h0, 32'h0000_0001, 0};
    vecs[14] = '{1'b0, 2'd0, 32'h0, 4'h0, 32'h0000_0000, 0};
    vecs[15] = '{1'b0, 2'd2, 32'h0, 4'h0, 32'h0000_0001, 0};
    for (int i = 0; i < 16; i++) begin
      bus(vecs[i].wr, vecs[i].off, vecs[i].wd, vecs[i].ws);
      chk($sformatf("vec%0d", i), last_rd, vecs[i].exp);
      repeat (vecs[i].gap) @(posedge clk);
    end

    // Out-of-window requests never get ready
    foreach (vecs[i]) if (i < 2) begin
      @(negedge clk);
      iomem_valid = 1'b1;
      iomem_addr  = (i == 0) ? Base + 32'h10 : 32'h0400_0008;
      iomem_wstrb = 4'h0;
      hits = 0;
      repeat (4) begin
        @(negedge clk);
        if (iomem_ready) hits++;
      end
      chk($sformatf("outside_window%0d", i), hits, 0);
      iomem_valid = 1'b0;
    end

    // 17 back-to-back gray pushes: last one is dropped
    for (int k = 0; k < 17; k++) begin
      logic [7:0] v;
      v = 8'(k * 15 + 3);
      bus(1'b1, 2'd0, {8'h0, v, v, v}, 4'hF);
    end
    repeat (4) @(posedge clk);
    bus(1'b0, 2'd2, 32'h0, 4'h0);
    chk("status_full_ovf", last_rd, 32'h0000_1006);
    chk("irq_full", last_irq, 1);
    for (int k = 1; k <= 16; k++) begin
      bus(1'b0, 2'd1, 32'h0, 4'h0);
      chk($sformatf("drain%0d", k), last_rd, 32'h8000_0000 | 32'((k - 1) * 15 + 3));
      chk($sformatf("drain_irq%0d", k), last_irq, (17 - k) >= IrqLevel);
    end
    bus(1'b0, 2'd1, 32'h0, 4'h0);
    chk("pop_empty", last_rd, 32'h0);
    bus(1'b0, 2'd2, 32'h0, 4'h0);
    chk("status_flags", last_rd, 32'h0000_000D);
    bus(1'b1, 2'd2, 32'h0000_000C, 4'h1);
    bus(1'b0, 2'd2, 32'h0, 4'h0);
    chk("status_w1c", last_rd, 32'h0000_0001);

    // Flush while pixels are still in the pipeline
    for (int k = 0; k < 3; k++) bus(1'b1, 2'd0, 32'h0040_4040, 4'hF);
    bus(1'b1, 2'd3, 32'h0000_0003, 4'h1);
    bus(1'b0, 2'd2, 32'h0, 4'h0);
    chk("status_after_flush", last_rd, 32'h0000_0001);
    repeat (4) @(posedge clk);
    bus(1'b0, 2'd1, 32'h0, 4'h0);
    chk("pop_after_flush", last_rd, 32'h0);
    bus(1'b0, 2'd3, 32'h0, 4'h0);
    chk("ctrl_after_flush", last_rd, 32'h0000_0001);
    bus(1'b1, 2'd2, 32'h0000_0008, 4'h1);

    // Disabled: pushes silently ignored
    bus(1'b1, 2'd3, 32'h0000_0000, 4'h1);
    bus(1'b1, 2'd0, 32'h00AB_CDEF, 4'hF);
    repeat (4) @(posedge clk);
    bus(1'b0, 2'd2, 32'h0, 4'h0);
    chk("status_disabled", last_rd, 32'h0000_0001);

    // Reset during the ready cycle of a PIX_IN write
    bus(1'b1, 2'd3, 32'h0000_0005, 4'h1);
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = Base;
    iomem_wdata = 32'h0080_8080;
    iomem_wstrb = 4'hF;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
    chk("ready_after_reset", iomem_ready, 0);
    repeat (4) @(posedge clk);
    bus(1'b0, 2'd3, 32'h0, 4'h0);
    chk("ctrl_after_reset", last_rd, 32'h0000_0001);
    bus(1'b0, 2'd2, 32'h0, 4'h0);
    chk("status_no_push", last_rd, 32'h0000_0001);

    // Random traffic against the model
    do_reset();
    m_en = 1'b1;
    m_inv = 1'b0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    pq.delete();
    for (int i = 0; i < 500; i++) begin
      int op, s, cnt, r;
      bit bsy;
      logic [31:0] wd, exp;
      logic [3:0] ws;
      op = $urandom_range(0, 9);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      wd = $urandom;
      ws = 4'($urandom_range(1, 15));
      unique case (op)
        0, 1, 2, 3: bus(1'b1, 2'd0, wd, ws);
        4, 5:       bus(1'b0, 2'd1, wd, ws);
        6:          bus(1'b0, 2'd2, wd, ws);
        7:          bus(1'b1, 2'd2, wd, ws);
        8: begin
          wd = {29'd0, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) != 0)};
          bus(1'b1, 2'd3, wd, ws);
        end
        default:    bus(1'b0, 2'd3, wd, ws);
      endcase
      // Model view at the setup cycle, one clock before ready
      s = last_cyc - 1;
      cnt = 0;
      bsy = 1'b0;
      foreach (pq[j]) begin
        if (pq[j].land <= s) cnt++;
        else bsy = 1'b1;
      end
      chk($sformatf("rnd%0d_irq", i), last_irq, m_en && cnt >= IrqLevel);
      exp = 32'h0;
      unique case (op)
        0, 1, 2, 3: begin
          if (m_en) begin
            if (pq.size() >= Depth) m_ovf = 1'b1;
            else pq.push_back('{luma(wd, m_inv), last_cyc + 3});
          end
        end
        4, 5: begin
          if (cnt > 0) begin
            r = pq.pop_front().y;
            exp = 32'h8000_0000 | 32'(r);
          end else begin
            m_udf = 1'b1;
          end
        end
        6: exp = {15'd0, 9'(cnt), 3'd0, bsy, m_udf, m_ovf, cnt == Depth, cnt == 0};
        7: begin
          if (wd[2]) m_ovf = 1'b0;
          if (wd[3]) m_udf = 1'b0;
        end
        8: begin
          if (ws[0]) begin
            m_en = wd[0];
            m_inv = wd[2];
            if (wd[1]) pq.delete();
          end
        end
        default: exp = {29'd0, m_inv, 1'b0, m_en};
      endcase
      chk($sformatf("rnd%0d_op%0d", i, op), last_rd, exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
